wb_arbiter2: RTL and testbench

Two-master, one-slave Wishbone B3 arbiter with round-robin fairness and cycle locking. It shares one slave port, such as the on-chip RAM or a peripheral window, between the processor instruction and data buses. Multiplexed slave-side outputs are combinational from the registered grant. Master 0 wins the first contested arbitration after reset.

---
 rtl/wb_arbiter2.sv | 194 +++++++++++++++++++
 tb/tb_wb_arbiter2.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone B3 arbiter with round-robin fairness and cycle locking.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that errors out a stalled slave transfer.
module wb_arbiter2 #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TGA_WIDTH  = 2,
  parameter int unsigned TGC_WIDTH  = 3,
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  // master 0
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  input  logic [TGA_WIDTH-1:0]  m0_tga_i,
  input  logic [TGC_WIDTH-1:0]  m0_tgc_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  // master 1
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  input  logic [TGA_WIDTH-1:0]  m1_tga_i,
  input  logic [TGC_WIDTH-1:0]  m1_tgc_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  // slave
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  output logic [TGA_WIDTH-1:0]  s_tga_o,
  output logic [TGC_WIDTH-1:0]  s_tgc_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  output logic [1:0]            gnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_e;

  state_e state;
  logic   last;
  logic   stb_mux_c;
  logic   timeout_c;
  logic   term_en_c;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("wb_arbiter2: TIMEOUT must be at least 1");
  end

  // Grant FSM: contested idle requests go to the master not granted last; owner keeps
  // the bus until it drops cyc, then the other master takes over on the next edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      last  <= 1'b1;
      gnt_o <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last)) begin
            state <= ST_GNT0;
            last  <= 1'b0;
            gnt_o <= 2'b01;
          end else if (m1_cyc_i) begin
            state <= ST_GNT1;
            last  <= 1'b1;
            gnt_o <= 2'b10;
          end
        end
        ST_GNT0: begin
          if (!m0_cyc_i) begin
            if (m1_cyc_i) begin
              state <= ST_GNT1;
              last  <= 1'b1;
              gnt_o <= 2'b10;
            end else begin
              state <= ST_IDLE;
              gnt_o <= 2'b00;
            end
          end
        end
        ST_GNT1: begin
          if (!m1_cyc_i) begin
            if (m0_cyc_i) begin
              state <= ST_GNT0;
              last  <= 1'b0;
              gnt_o <= 2'b01;
            end else begin
              state <= ST_IDLE;
              gnt_o <= 2'b00;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt_o <= 2'b00;
        end
      endcase
    end
  end

  // Slave-side request mux, all zero while idle
  always_comb begin
    s_cyc_o   = 1'b0;
    stb_mux_c = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_tga_o   = '0;
    s_tgc_o   = '0;
    case (state)
      ST_GNT0: begin
        s_cyc_o   = m0_cyc_i;
        stb_mux_c = m0_stb_i;
        s_we_o    = m0_we_i;
        s_adr_o   = m0_adr_i;
        s_dat_o   = m0_dat_i;
        s_sel_o   = m0_sel_i;
        s_tga_o   = m0_tga_i;
        s_tgc_o   = m0_tgc_i;
      end
      ST_GNT1: begin
        s_cyc_o   = m1_cyc_i;
        stb_mux_c = m1_stb_i;
        s_we_o    = m1_we_i;
        s_adr_o   = m1_adr_i;
        s_dat_o   = m1_dat_i;
        s_sel_o   = m1_sel_i;
        s_tga_o   = m1_tga_i;
        s_tgc_o   = m1_tgc_i;
      end
      default: ;
    endcase
  end

  assign s_stb_o = stb_mux_c && !timeout_c;

  // Terminations reach only the owner; anything arriving during reset is dropped.
  assign term_en_c = !reset;
  assign m0_ack_o  = (state == ST_GNT0) && term_en_c && s_ack_i;
  assign m0_err_o  = (state == ST_GNT0) && term_en_c && (s_err_i || timeout_c);
  assign m0_rty_o  = (state == ST_GNT0) && term_en_c && s_rty_i;
  assign m1_ack_o  = (state == ST_GNT1) && term_en_c && s_ack_i;
  assign m1_err_o  = (state == ST_GNT1) && term_en_c && (s_err_i || timeout_c);
  assign m1_rty_o  = (state == ST_GNT1) && term_en_c && s_rty_i;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT + 1);

  logic [CNT_WIDTH-1:0] wdog_cnt;

  // Counts stalled strobe cycles of the owner; a grant entry always follows a cycle
  // with the owner's cyc low (or idle), so clearing there covers the entry case.
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_cnt <= '0;
    end else if (!s_cyc_o || timeout_c || s_ack_i || s_err_i || s_rty_i) begin
      wdog_cnt <= '0;
    end else if (stb_mux_c) begin
      wdog_cnt <= wdog_cnt + CNT_WIDTH'(1);
    end
  end

  assign timeout_c = (wdog_cnt == CNT_WIDTH'(TIMEOUT));
`else
  assign timeout_c = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed scenarios plus randomized traffic against a behavioural
// arbiter model (owner / last-winner / stall count) checked every cycle.
module tb_wb_arbiter2;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned TMO = 4;

  logic clock = 1'b0;
  logic reset;

  logic          m_cyc [2];
  logic          m_stb [2];
  logic          m_we  [2];
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic [SW-1:0] m_sel [2];
  logic [1:0]    m_tga [2];
  logic [2:0]    m_tgc [2];

  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m0_err_o, m0_rty_o;
  logic          m1_ack_o, m1_err_o, m1_rty_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic [1:0]    s_tga_o;
  logic [2:0]    s_tgc_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i, s_err_i, s_rty_i;
  logic [1:0]    gnt_o;

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_en   = 1'b0;

  wb_arbiter2 #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_adr_i(m_adr[0]),
    .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_tga_i(m_tga[0]), .m0_tgc_i(m_tgc[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_adr_i(m_adr[1]),
    .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_tga_i(m_tga[1]), .m1_tgc_i(m_tgc[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_tga_o(s_tga_o), .s_tgc_o(s_tgc_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0; m_adr[m] = '0;
      m_dat[m] = '0;   m_sel[m] = '0;   m_tga[m] = '0;  m_tgc[m] = '0;
    end
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
  endtask

  // Reference model: current owner (-1 = nobody), who won last, and how long the
  // owner has been strobing without any slave termination.
  int owner    = -1;
  bit last_m1  = 1'b1;
  int wait_cnt = 0;

  function automatic bit model_tmo();
`ifdef WB_ARB_TIMEOUT_EN
    return (owner >= 0) && (wait_cnt == int'(TMO));
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clock) begin
    int nxt;
    bit tmo;
    tmo = model_tmo();
    if (reset) begin
      owner = -1; last_m1 = 1'b1; wait_cnt = 0;
    end else begin
      if (owner < 0 || !m_cyc[owner] || tmo || s_ack_i || s_err_i || s_rty_i) wait_cnt = 0;
      else if (m_stb[owner]) wait_cnt++;
      nxt = owner;
      if (owner < 0) begin
        if (m_cyc[0] && m_cyc[1]) nxt = last_m1 ? 0 : 1;
        else if (m_cyc[0])        nxt = 0;
        else if (m_cyc[1])        nxt = 1;
      end else if (!m_cyc[owner]) begin
        nxt = m_cyc[1 - owner] ? 1 - owner : -1;
      end
      if (nxt >= 0 && nxt != owner) last_m1 = (nxt == 1);
      owner = nxt;
    end
  end

  always @(negedge clock) begin
    bit tmo, ok;
    logic [1:0] eg;
    logic [2:0] ectl, t0, t1;
    logic [AW-1:0] eadr;
    logic [DW-1:0] edat;
    logic [SW+4:0] eside;
    if (chk_en) begin
      tmo = model_tmo();
      ok  = !reset;
      eg = 2'b00; ectl = '0; eadr = '0; edat = '0; eside = '0; t0 = '0; t1 = '0;
      if (owner >= 0) begin
        eg    = (owner == 0) ? 2'b01 : 2'b10;
        ectl  = {m_cyc[owner], m_stb[owner] && !tmo, m_we[owner]};
        eadr  = m_adr[owner];
        edat  = m_dat[owner];
        eside = {m_sel[owner], m_tga[owner], m_tgc[owner]};
      end
      if (owner == 0) t0 = {s_ack_i && ok, (s_err_i || tmo) && ok, s_rty_i && ok};
      if (owner == 1) t1 = {s_ack_i && ok, (s_err_i || tmo) && ok, s_rty_i && ok};
      check("gnt", 64'(gnt_o), 64'(eg));
      check("s_ctl", 64'({s_cyc_o, s_stb_o, s_we_o}), 64'(ectl));
      check("s_adr", 64'(s_adr_o), 64'(eadr));
      check("s_dat", 64'(s_dat_o), 64'(edat));
      check("s_sel_tag", 64'({s_sel_o, s_tga_o, s_tgc_o}), 64'(eside));
      check("term", 64'({m1_ack_o, m1_err_o, m1_rty_o, m0_ack_o, m0_err_o, m0_rty_o}),
            64'({t1, t0}));
      check("rdat", {m1_dat_o, m0_dat_o}, {s_dat_i, s_dat_i});
    end
  end

  initial begin
    int errs, drops;
    reset = 1'b1;
    idle_inputs();
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_gnt", 64'(gnt_o), 64'(0));
    check("rst_sbus", 64'({s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o}), 64'(0));

    // single read by m0, slave acks on its 2nd cycle
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h7000_0004; m_sel[0] = 4'hf;
    @(negedge clock);
    check("t1_no_gnt_yet", 64'(gnt_o), 64'(2'b00));
    tick();
    @(negedge clock);
    check("t1_gnt", 64'(gnt_o), 64'(2'b01));
    check("t1_sadr", 64'(s_adr_o), 64'(32'h7000_0004));
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    @(negedge clock);
    check("t1_ack", 64'({m1_ack_o, m0_ack_o}), 64'(2'b01));
    check("t1_dat", 64'(m0_dat_o), 64'(32'hDEAD_BEEF));
    tick();
    idle_inputs();
    tick();

    // three simultaneous contests from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [1:0] win;
      win = (k == 1) ? 2'b10 : 2'b01;
      m_cyc[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[0] = 1'b1; m_stb[1] = 1'b1;
      @(negedge clock);
      check("t2_gap", 64'(gnt_o), 64'(2'b00));
      tick();
      @(negedge clock);
      check("t2_win", 64'(gnt_o), 64'(win));
      tick();
      idle_inputs();
      @(negedge clock);
      check("t2_drop", 64'(gnt_o), 64'(win));
      tick();
    end

    // m1 4-beat burst while m0 keeps requesting
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(negedge clock);
    check("t3_gnt", 64'(gnt_o), 64'(2'b10));
    for (int b = 0; b < 4; b++) begin
      tick();
      s_ack_i = 1'b1; m_adr[1] = 32'h100 + 32'(4 * b);
      @(negedge clock);
      check("t3_hold", 64'(gnt_o), 64'(2'b10));
      check("t3_acks", 64'({m1_ack_o, m0_ack_o}), 64'(2'b10));
    end
    tick();
    s_ack_i = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    @(negedge clock);
    check("t3_drop", 64'(gnt_o), 64'(2'b10));
    tick();
    @(negedge clock);
    check("t3_handover", 64'(gnt_o), 64'(2'b01));
    tick();
    idle_inputs();
    tick();

    // reset mid-transfer with the ack pending
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    @(negedge clock);
    check("t4_gnt0", 64'(gnt_o), 64'(2'b01));
    tick();
    reset = 1'b1; s_ack_i = 1'b1;
    @(negedge clock);
    check("t4_ack_in_rst", 64'({m1_ack_o, m0_ack_o}), 64'(0));
    tick();
    reset = 1'b0; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(negedge clock);
    check("t4_idle", 64'({gnt_o, s_cyc_o, m1_ack_o, m0_ack_o}), 64'(0));
    tick();
    s_ack_i = 1'b0;
    @(negedge clock);
    check("t4_contest", 64'(gnt_o), 64'(2'b01));
    tick();
    idle_inputs();
    tick();

    // m1 strobes a slave that never answers
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      check("t5_err", 64'(m1_err_o), 64'(c == 4));
      if (c == 4) check("t5_stb_low", 64'(s_stb_o), 64'(0));
      tick();
    end
`else
    errs = 0; drops = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      if (m0_err_o || m1_err_o) errs++;
      if (gnt_o != 2'b10) drops++;
      tick();
    end
    check("t5_no_err", 64'(errs), 64'(0));
    check("t5_held", 64'(drops), 64'(0));
`endif
    idle_inputs();
    tick();
    tick();

    // randomized traffic, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (m_cyc[m]) begin
          if ($urandom_range(5) == 0) m_cyc[m] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          m_cyc[m] = 1'b1;
        end
        m_stb[m] = m_cyc[m] && ($urandom_range(3) != 0);
        m_we[m]  = 1'($urandom);
        m_adr[m] = $urandom;
        m_dat[m] = $urandom;
        m_sel[m] = SW'($urandom);
        m_tga[m] = 2'($urandom);
        m_tgc[m] = 3'($urandom);
      end
      s_dat_i = $urandom;
      s_ack_i = ($urandom_range(3) == 0);
      s_err_i = ($urandom_range(15) == 0);
      s_rty_i = ($urandom_range(15) == 0);
      reset   = ($urandom_range(199) == 0);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
